// File: rtl/mil1553_tx_encoder.sv
// MIL-STD-1553 Manchester II transmit encoder: sync, 16 data bits and odd parity on a differential pair.
// Half-bit 0 appears the cycle after accept; tready only when idle or on the last cycle of a word.
module mil1553_tx_encoder #(
  parameter int CLOCK_SPEED = 100000000,
  parameter bit INVERT_DATA = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  o_diff,
  output logic        en_o_diff,
  output logic        o_busy
);

  localparam int HALF_CLKS = CLOCK_SPEED / 2000000;
  localparam int PW = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(HALF_CLKS - 1);
  localparam logic [5:0] HLAST = 6'd39;

  typedef enum logic {IDLE, TX} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [5:0]    hcnt;
  logic [16:0]   word_bits;   // {data, parity}, MSB first on the wire
  logic          sync_cmd;
  logic          word_end;
  logic          accept;

  // Pre-inversion line level for half-bit h: 3+3 sync halves, then bit/complement pairs.
  function automatic logic level(input logic [5:0] h, input logic [16:0] bits, input logic cmd);
    logic [5:0] k;
    logic       lv;
    k = (h - 6'd6) >> 1;
    if (h < 6'd3)
      lv = cmd;
    else if (h < 6'd6)
      lv = ~cmd;
    else
      lv = bits[5'd16 - k[4:0]] ^ h[0];
    return lv;
  endfunction

  function automatic logic [1:0] drive(input logic lv);
    return INVERT_DATA ? {~lv, lv} : {lv, ~lv};
  endfunction

  assign word_end      = (state == TX) && (hcnt == HLAST) && (pcnt == PMAX);
  assign s_axis_tready = ~rst && ((state == IDLE) || word_end);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      word_bits <= '0;
      sync_cmd  <= 1'b0;
      o_diff    <= 2'b00;
      en_o_diff <= 1'b0;
      o_busy    <= 1'b0;
    end else if (accept) begin
      // Also covers the last cycle of a word, giving gapless back-to-back output.
      state     <= TX;
      pcnt      <= '0;
      hcnt      <= '0;
      word_bits <= {s_axis_tdata, ~^s_axis_tdata};
      sync_cmd  <= s_axis_tuser;
      o_diff    <= drive(s_axis_tuser);
      en_o_diff <= 1'b1;
      o_busy    <= 1'b1;
    end else if (state == TX) begin
      if (pcnt == PMAX) begin
        pcnt <= '0;
        if (hcnt == HLAST) begin
          state     <= IDLE;
          hcnt      <= '0;
          o_diff    <= 2'b00;
          en_o_diff <= 1'b0;
          o_busy    <= 1'b0;
        end else begin
          hcnt   <= hcnt + 6'd1;
          o_diff <= drive(level(hcnt + 6'd1, word_bits, sync_cmd));
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mil1553_tx_encoder.sv
// Directed bench for mil1553_tx_encoder: default, inverted and fast-clock instances share one stimulus.
module tb_mil1553_tx_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tdata = 16'h0;
  logic        tuser = 1'b0;
  logic        tvalid = 1'b0;

  logic       rdy0, rdy1, rdy2;
  logic [1:0] od0, od1, od2;
  logic       en0, en1, en2;
  logic       bsy0, bsy1, bsy2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mil1553_tx_encoder #(.CLOCK_SPEED(100000000), .INVERT_DATA(1'b0)) dut_norm (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy0), .o_diff(od0), .en_o_diff(en0), .o_busy(bsy0));

  mil1553_tx_encoder #(.CLOCK_SPEED(100000000), .INVERT_DATA(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy1), .o_diff(od1), .en_o_diff(en1), .o_busy(bsy1));

  mil1553_tx_encoder #(.CLOCK_SPEED(4000000), .INVERT_DATA(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy2), .o_diff(od2), .en_o_diff(en2), .o_busy(bsy2));

  function automatic logic [1:0] get_od(input int sel);
    return (sel == 0) ? od0 : (sel == 1) ? od1 : od2;
  endfunction
  function automatic logic get_en(input int sel);
    return (sel == 0) ? en0 : (sel == 1) ? en1 : en2;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bsy0 : (sel == 1) ? bsy1 : bsy2;
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Expects the accept on the next rising edge, then checks one 40-half-bit word;
  // the next word's inputs are applied right after that accept edge.
  task automatic check_word(input int sel, input logic [15:0] w, input logic u,
                            input logic nv, input logic [15:0] nd, input logic nu,
                            input string name, output logic obs_p);
    int half;
    logic lv[40];
    logic p;
    logic [1:0] want, got, first;
    logic bad, en_bad, rdy_bad, rdy_exp;
    half = (sel == 2) ? 2 : 50;
    p = ~^w;
    for (int h = 0; h < 3; h++) lv[h] = u;
    for (int h = 3; h < 6; h++) lv[h] = ~u;
    for (int i = 0; i < 16; i++) begin
      lv[6 + 2*i] = w[15 - i];
      lv[7 + 2*i] = ~w[15 - i];
    end
    lv[38] = p;
    lv[39] = ~p;
    obs_p = 1'bx;
    en_bad = 1'b0;
    rdy_bad = 1'b0;
    @(posedge clk); #1;
    tvalid = nv; tdata = nd; tuser = nu;
    for (int h = 0; h < 40; h++) begin
      want = (sel == 1) ? {~lv[h], lv[h]} : {lv[h], ~lv[h]};
      bad = 1'b0;
      first = 2'b00;
      for (int c = 0; c < half; c++) begin
        @(negedge clk);
        got = get_od(sel);
        if (got !== want && !bad) begin bad = 1'b1; first = got; end
        if (get_en(sel) !== 1'b1 || get_busy(sel) !== 1'b1) en_bad = 1'b1;
        rdy_exp = (h == 39 && c == half - 1);
        if (get_rdy(sel) !== rdy_exp) rdy_bad = 1'b1;
        if (h == 38) obs_p = (sel == 1) ? got[0] : got[1];
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s half-bit %0d: o_diff=%b expected %b", name, h, first, want);
      end
    end
    n_checks++;
    if (en_bad) begin
      n_fail++;
      $display("FAIL %s en/busy: dropped during word, expected 1 throughout", name);
    end
    n_checks++;
    if (rdy_bad) begin
      n_fail++;
      $display("FAIL %s tready: not a single pulse on last cycle of word", name);
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    @(negedge clk);
    n_checks++;
    if (get_od(sel) !== 2'b00 || get_en(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: o_diff=%b en=%b busy=%b expected 00/0/0",
               name, get_od(sel), get_en(sel), get_busy(sel));
    end
  endtask

  task automatic test_reset();
    tvalid = 1'b1; tdata = 16'hFFFF; tuser = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (od0 !== 2'b00 || en0 !== 1'b0 || bsy0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: o_diff=%b en=%b busy=%b tready=%b expected 00/0/0/0",
               od0, en0, bsy0, rdy0);
    end
    @(posedge clk); #1;
    tvalid = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy0 !== 1'b1 || od0 !== 2'b00 || en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: tready=%b o_diff=%b en=%b expected 1/00/0", rdy0, od0, en0);
    end
  endtask

  task automatic test_command();
    logic p;
    do_reset();
    tvalid = 1'b1; tdata = 16'h1234; tuser = 1'b1;
    check_word(0, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, "cmd_1234", p);
    n_checks++;
    if (p !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_1234 parity: got %b expected 0", p);
    end
    check_idle(0, "cmd_1234");
  endtask

  task automatic test_data_word();
    logic p;
    do_reset();
    tvalid = 1'b1; tdata = 16'hFFFF; tuser = 1'b0;
    check_word(0, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, "data_FFFF", p);
    n_checks++;
    if (p !== 1'b1) begin
      n_fail++;
      $display("FAIL data_FFFF parity: got %b expected 1", p);
    end
    check_idle(0, "data_FFFF");
  endtask

  task automatic test_parity();
    logic p;
    logic [15:0] w[65];
    do_reset();
    tvalid = 1'b1; tdata = 16'h0000; tuser = 1'b0;
    check_word(2, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, "par_0000", p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL par_0000: parity %b expected 1", p); end
    check_idle(2, "par_0000");
    tvalid = 1'b1; tdata = 16'h0001; tuser = 1'b1;
    check_word(2, 16'h0001, 1'b1, 1'b0, 16'h0, 1'b0, "par_0001", p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL par_0001: parity %b expected 0", p); end
    check_idle(2, "par_0001");
    do_reset();
    for (int i = 0; i < 65; i++) w[i] = 16'($urandom);
    tvalid = 1'b1; tdata = w[0]; tuser = 1'b0;
    for (int n = 0; n < 64; n++) begin
      check_word(2, w[n], 1'b0, (n < 63), w[n+1], 1'b0, "par_rand", p);
      n_checks++;
      if (($countones(w[n]) + int'(p)) % 2 != 1) begin
        n_fail++;
        $display("FAIL par_rand word %h: parity %b gives even ones count", w[n], p);
      end
    end
    check_idle(2, "par_rand");
  endtask

  task automatic test_back_to_back();
    logic p;
    do_reset();
    tvalid = 1'b1; tdata = 16'hC0DE; tuser = 1'b1;
    check_word(0, 16'hC0DE, 1'b1, 1'b1, 16'h0F0F, 1'b0, "b2b_w0", p);
    check_word(0, 16'h0F0F, 1'b0, 1'b1, 16'h8001, 1'b0, "b2b_w1", p);
    check_word(0, 16'h8001, 1'b0, 1'b0, 16'h0, 1'b0, "b2b_w2", p);
    check_idle(0, "b2b_end");
  endtask

  task automatic test_reset_midword();
    logic p;
    do_reset();
    tvalid = 1'b1; tdata = 16'h5555; tuser = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    repeat (20 * 50 + 10) @(posedge clk);
    #1;
    rst = 1'b1; tvalid = 1'b1; tdata = 16'hA5A5; tuser = 1'b0;
    @(negedge clk);
    n_checks++;
    if (od0 === 2'b00 || en0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midword_pre: o_diff=%b en=%b expected active word before reset", od0, en0);
    end
    @(negedge clk);
    n_checks++;
    if (od0 !== 2'b00 || en0 !== 1'b0 || bsy0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midword_abort: o_diff=%b en=%b busy=%b tready=%b expected 00/0/0/0",
               od0, en0, bsy0, rdy0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_word(0, 16'hA5A5, 1'b0, 1'b0, 16'h0, 1'b0, "after_reset_A5A5", p);
    check_idle(0, "after_reset_A5A5");
  endtask

  task automatic test_invert();
    logic p;
    do_reset();
    tvalid = 1'b1; tdata = 16'h8000; tuser = 1'b1;
    @(negedge clk);
    n_checks++;
    if (od1 !== 2'b00) begin
      n_fail++;
      $display("FAIL invert_idle_pre: o_diff=%b expected 00", od1);
    end
    check_word(1, 16'h8000, 1'b1, 1'b0, 16'h0, 1'b0, "invert_8000", p);
    check_idle(1, "invert_8000");
  endtask

  initial begin
    test_reset();
    test_command();
    test_data_word();
    test_parity();
    test_back_to_back();
    test_reset_midword();
    test_invert();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
